// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce feeding a four-function calculator entry FSM.
// Produces two BCD-entered operands, an operation code and a one-cycle start pulse.
module keypad_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [13:0] op1,
  output logic [13:0] op2,
  output logic [1:0]  operation,
  output logic        start,
  output logic [15:0] entry_bcd
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE_PRESS, WAIT_RELEASE} scan_state_e;
  typedef enum logic [1:0] {OP1, OP2, DONE} entry_state_e;

  scan_state_e      scan_q;
  entry_state_e     entry_q;
  logic [3:0]       row_meta_q, rs_q, pat_q;
  logic [1:0]       col_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_valid_q, start_q;
  logic [3:0]       key_code_q;
  logic [13:0]      op1_q, op2_q;
  logic [1:0]       operation_q;
  logic [15:0]      bcd_q;
  logic [2:0]       digits_q;
  logic [3:0]       key_dec;

  // Key code for the latched row pattern on the frozen column.
  function automatic logic [3:0] decode_key(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] r;
    logic [3:0] code;
    r = 2'd0;
    case (pat)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    case ({r, c})
      4'h0: code = 4'd1;   4'h1: code = 4'd2;  4'h2: code = 4'd3;  4'h3: code = 4'd10;
      4'h4: code = 4'd4;   4'h5: code = 4'd5;  4'h6: code = 4'd6;  4'h7: code = 4'd11;
      4'h8: code = 4'd7;   4'h9: code = 4'd8;  4'hA: code = 4'd9;  4'hB: code = 4'd12;
      4'hC: code = 4'd14;  4'hD: code = 4'd0;  4'hE: code = 4'd15; default: code = 4'd13;
    endcase
    return code;
  endfunction

  function automatic logic [13:0] append_digit(input logic [13:0] v, input logic [3:0] d);
    return v * 14'd10 + {10'd0, d};
  endfunction

  assign key_dec = decode_key(pat_q, col_idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= 4'h0;
      rs_q        <= 4'h0;
      scan_q      <= SCAN;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      pat_q       <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking (<=) for every register so all flops update from pre-edge values.
      row_meta_q  <= row;
      rs_q        <= row_meta_q;
      key_valid_q <= 1'b0;
      unique case (scan_q)
        SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= '0;
            if ($onehot(~rs_q)) begin
              pat_q  <= rs_q;
              scan_q <= DEBOUNCE_PRESS;
            end else begin
              col_idx_q <= col_idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DEBOUNCE_PRESS: begin
          if (rs_q != pat_q) begin
            scan_q    <= SCAN;
            col_idx_q <= col_idx_q + 2'd1;
            cnt_q     <= '0;
          end else if (cnt_q == DEB_LAST) begin
            key_valid_q <= 1'b1;
            key_code_q  <= key_dec;
            scan_q      <= WAIT_RELEASE;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (rs_q != 4'hF) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            scan_q    <= SCAN;
            col_idx_q <= col_idx_q + 2'd1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: scan_q <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q     <= OP1;
      op1_q       <= 14'd0;
      op2_q       <= 14'd0;
      operation_q <= 2'b00;
      bcd_q       <= 16'h0;
      digits_q    <= 3'd0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (key_valid_q) begin
        if (key_code_q <= 4'd9) begin
          if (entry_q == DONE) begin
            op1_q    <= {10'd0, key_code_q};
            op2_q    <= 14'd0;
            bcd_q    <= {12'h0, key_code_q};
            digits_q <= 3'd1;
            entry_q  <= OP1;
          end else if (digits_q != 3'd4) begin
            if (entry_q == OP1) op1_q <= append_digit(op1_q, key_code_q);
            else                op2_q <= append_digit(op2_q, key_code_q);
            bcd_q    <= {bcd_q[11:0], key_code_q};
            digits_q <= digits_q + 3'd1;
          end
        end else begin
          case (key_code_q)
            4'd14: begin
              op1_q       <= 14'd0;
              op2_q       <= 14'd0;
              operation_q <= 2'b00;
              bcd_q       <= 16'h0;
              digits_q    <= 3'd0;
              entry_q     <= OP1;
            end
            4'd15: begin
              if (entry_q == OP2 && digits_q != 3'd0) begin
                start_q <= 1'b1;
                entry_q <= DONE;
              end
            end
            default: begin
              // Codes 10..13 map to operations 0..3.
              if (entry_q == OP1) begin
                operation_q <= key_code_q[1:0] - 2'd2;
                op2_q       <= 14'd0;
                bcd_q       <= 16'h0;
                digits_q    <= 3'd0;
                entry_q     <= OP2;
              end else if (entry_q == OP2 && digits_q == 3'd0) begin
                operation_q <= key_code_q[1:0] - 2'd2;
              end
            end
          endcase
        end
      end
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign operation = operation_q;
  assign start     = start_q;
  assign entry_bcd = bcd_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model drives rows from the column strobe; a scoreboard
// queue of expected keys and calculator state is checked by an independent monitor.
module tb_keypad_entry;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] op1, op2;
  logic [1:0]  operation;
  logic        start;
  logic [15:0] entry_bcd;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_valid(key_valid),
    .key_code(key_code), .op1(op1), .op2(op2), .operation(operation),
    .start(start), .entry_bcd(entry_bcd)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key at (pr, pc) pulls row pr low while column pc is driven.
  bit         pressed  = 1'b0;
  int         pr = 0, pc = 0;
  bit         force_en = 1'b0;
  logic [3:0] force_row = 4'hF;
  int         layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  always_comb begin
    row = 4'hF;
    if (force_en) row = force_row;
    else if (pressed && col[pc[1:0]] == 1'b0) row[pr[1:0]] = 1'b0;
  end

  typedef struct {
    int code; int op1; int op2; int opn; int bcd; bit start;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int n_kv = 0, n_start = 0, exp_kv = 0, exp_start = 0;

  // Calculator reference: field 0 = entering op1, 1 = entering op2, 2 = result requested.
  int m_op1, m_op2, m_opn, m_cnt, m_field;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v % 10) | ((v / 10 % 10) << 4) | ((v / 100 % 10) << 8) | ((v / 1000 % 10) << 12);
  endfunction

  function automatic void model_reset();
    m_op1 = 0; m_op2 = 0; m_opn = 0; m_cnt = 0; m_field = 0;
  endfunction

  function automatic exp_t model_key(input int code);
    exp_t e;
    e.start = 1'b0;
    if (code <= 9) begin
      if (m_field == 2) begin
        m_op1 = code; m_op2 = 0; m_cnt = 1; m_field = 0;
      end else if (m_cnt < 4) begin
        if (m_field == 0) m_op1 = m_op1 * 10 + code;
        else              m_op2 = m_op2 * 10 + code;
        m_cnt++;
      end
    end else if (code == 14) begin
      model_reset();
    end else if (code == 15) begin
      if (m_field == 1 && m_cnt > 0) begin
        e.start = 1'b1; m_field = 2;
      end
    end else begin
      if (m_field == 0) begin
        m_opn = code - 10; m_op2 = 0; m_cnt = 0; m_field = 1;
      end else if (m_field == 1 && m_cnt == 0) begin
        m_opn = code - 10;
      end
    end
    e.code = code; e.op1 = m_op1; e.op2 = m_op2; e.opn = m_opn;
    e.bcd  = to_bcd(m_field == 0 ? m_op1 : m_op2);
    return e;
  endfunction

  // Monitor: pops one expectation per key_valid, checks the entry state one cycle later.
  exp_t cur;
  bit   post = 1'b0;
  always @(negedge clk) begin
    if (start) n_start++;
    if (post) begin
      check("op1", op1, cur.op1);
      check("op2", op2, cur.op2);
      check("operation", operation, cur.opn);
      check("entry_bcd", entry_bcd, cur.bcd);
      check("start", start, cur.start);
      post = 1'b0;
    end
    if (key_valid) begin
      n_kv++;
      if (exp_q.size() == 0) check("key_valid_expected", 0, 1);
      else begin
        cur = exp_q.pop_front();
        check("key_code", key_code, cur.code);
        post = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; pressed = 1'b0; force_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic press(input int code, input int hold);
    exp_t e;
    bit   seen;
    int   pos;
    e = model_key(code);
    exp_q.push_back(e);
    exp_kv++;
    if (e.start) exp_start++;
    pos = 0;
    for (int i = 0; i < 16; i++) if (layout[i] == code) pos = i;
    pr = pos / 4; pc = pos % 4; pressed = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    if (!seen) check("press_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    repeat (DEBOUNCE + SCAN_DIV + 6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int kv0, st0, n;
    logic [3:0] exp_col;
    model_reset();

    // Reset state and column rotation.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_operation", operation, 0);
    check("rst_start", start, 0);
    check("rst_entry_bcd", entry_bcd, 0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("col_rotate", col, exp_col);
    end

    // Short glitch on row 0 during column 0: rejected, scanning resumes on column 1.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; force_en = 1'b1; force_row = 4'b1110;
    kv0 = n_kv;
    for (int k = 1; k <= 5; k++) @(posedge clk);
    @(negedge clk);
    force_en = 1'b0;
    n = 5;
    while (col == 4'b1110 && n < 40) begin
      @(posedge clk); n++; #1;
    end
    check("glitch_col_change_cycle", n, 8);
    check("glitch_col", col, 4'b1101);
    repeat (30) @(negedge clk);
    check("glitch_no_key_valid", n_kv - kv0, 0);

    // 1 2 + 3 =
    do_reset();
    st0 = n_start;
    press(1, 20); press(2, 20); press(10, 20); press(3, 20); press(15, 20);
    check("add_op1", op1, 12);
    check("add_op2", op2, 3);
    check("add_operation", operation, 0);
    check("add_entry_bcd", entry_bcd, 16'h0003);
    check("add_start_cycles", n_start - st0, 1);

    // Five digits: fifth ignored; a long hold gives one key_valid.
    do_reset();
    press(1, 2); press(2, 2); press(3, 2); press(4, 2); press(5, 2);
    check("digits_op1", op1, 1234);
    check("digits_entry_bcd", entry_bcd, 16'h1234);
    kv0 = n_kv;
    press(6, 200);
    check("held_key_pulses", n_kv - kv0, 1);

    // 7 * - 9 = 4
    do_reset();
    st0 = n_start;
    press(7, 3); press(12, 3); press(11, 3); press(9, 3); press(15, 3);
    check("sub_operation", operation, 1);
    check("sub_start_cycles", n_start - st0, 1);
    press(4, 3);
    check("restart_op1", op1, 4);
    check("restart_op2", op2, 0);
    check("restart_entry_bcd", entry_bcd, 16'h0004);

    // 5 + 6 clear
    do_reset();
    st0 = n_start;
    press(5, 3); press(10, 3); press(6, 3); press(14, 3);
    check("clear_op1", op1, 0);
    check("clear_op2", op2, 0);
    check("clear_operation", operation, 0);
    check("clear_entry_bcd", entry_bcd, 0);
    check("clear_no_start", n_start - st0, 0);

    // Reset in the middle of a debounce and of an entry.
    press(5, 3); press(10, 3); press(6, 3);
    kv0 = n_kv; st0 = n_start;
    force_en = 1'b1; force_row = 4'b1110;
    repeat (7) @(negedge clk);
    do_reset();
    repeat (60) @(negedge clk);
    check("midrst_no_key_valid", n_kv - kv0, 0);
    check("midrst_no_start", n_start - st0, 0);
    check("midrst_op1", op1, 0);
    check("midrst_op2", op2, 0);
    check("midrst_entry_bcd", entry_bcd, 0);

    // Random key sequences against the reference.
    do_reset();
    for (int i = 0; i < 40; i++) press($urandom_range(0, 15), $urandom_range(0, 10));

    check("total_key_valid", n_kv, exp_kv);
    check("total_start", n_start, exp_start);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
